// File: rtl/sprite_arb_pkg.sv
// Shared types and constants for the sprite image BROM arbiter.
package sprite_arb_pkg;

  localparam int MAX_REQ         = 8;
  localparam int IDX_W           = 3;
  localparam int DEF_ROM_LATENCY = 2;

  typedef logic [IDX_W-1:0] req_idx_t;

  // One in-flight read: which requester owns the data when it comes back.
  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } arb_tag_t;

  localparam arb_tag_t TAG_NONE = '{valid: 1'b0, idx: '0};

  // Round-robin successor of a requester index, wrapping at num_req.
  function automatic req_idx_t next_idx(input req_idx_t idx, input int num_req);
    return (int'(idx) == num_req - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// Combinational round-robin select: first requester at or after rr_ptr,
// wrapping to the lowest requester below rr_ptr when none is found above.
module rr_picker
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           rr_ptr,
  output logic               found,
  output req_idx_t           winner
);

  logic     hi_found;
  req_idx_t hi_idx;
  req_idx_t lo_idx;

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    found    = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found  = 1'b1;
        lo_idx = req_idx_t'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = req_idx_t'(i);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite image BROM among several renderers.
// Grants one read per clock and returns the data tagged to its issuer.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = DEF_ROM_LATENCY
) (
  input  logic                           pixel_clk_in,
  input  logic                           rst_n_in,
  input  logic [NUM_REQ-1:0]             req_in,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_in,
  output logic [NUM_REQ-1:0]             grant_out,
  output logic [ADDR_W-1:0]              rom_addr_out,
  input  logic [DATA_W-1:0]              rom_data_in,
  output logic [DATA_W-1:0]              data_out,
  output logic [NUM_REQ-1:0]             valid_out
);

  logic               pick_found;
  req_idx_t           pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ADDR_W-1:0]  pick_addr;
  req_idx_t           rr_ptr;

  // issue_tag sits alongside rom_addr_out; tag_pipe delays it so the last
  // stage lines up with rom_data_in for the same read.
  arb_tag_t           issue_tag;
  arb_tag_t           tag_pipe [ROM_LATENCY];
  logic [NUM_REQ-1:0] ret_onehot;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req_in),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .winner (pick_idx)
  );

  // Decode the winner into a one-hot grant and mux its address.
  always_comb begin
    pick_onehot = '0;
    pick_addr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_found && (pick_idx == req_idx_t'(i))) begin
        pick_onehot[i] = 1'b1;
        pick_addr      = addr_in[i];
      end
    end
  end

  // Register the grant, BROM address and round-robin pointer.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      grant_out    <= '0;
      rom_addr_out <= '0;
      rr_ptr       <= '0;
      issue_tag    <= TAG_NONE;
    end else if (pick_found) begin
      grant_out    <= pick_onehot;
      rom_addr_out <= pick_addr;
      rr_ptr       <= next_idx(pick_idx, NUM_REQ);
      issue_tag    <= '{valid: 1'b1, idx: pick_idx};
    end else begin
      grant_out    <= '0;
      issue_tag    <= TAG_NONE;
    end
  end

  // Shift tags along with the BROM read latency; reset drops in-flight reads.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < ROM_LATENCY; k++) begin
        tag_pipe[k] <= TAG_NONE;
      end
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  // Owner of the data currently on rom_data_in.
  always_comb begin
    ret_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_pipe[ROM_LATENCY-1].valid && (tag_pipe[ROM_LATENCY-1].idx == req_idx_t'(i))) begin
        ret_onehot[i] = 1'b1;
      end
    end
  end

  // Register returned data together with its owner.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_out  <= '0;
      valid_out <= '0;
    end else begin
      data_out  <= rom_data_in;
      valid_out <= ret_onehot;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: vector table with hand-derived grants,
// BROM model returning addr[7:0], scoreboard of expected returns.
module tb_sprite_rom_arbiter;

  localparam int N   = 4;
  localparam int AW  = 15;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       req_in = '0;
  logic [N-1:0][AW-1:0] addr_in = '0;
  logic [N-1:0]       grant_out;
  logic [AW-1:0]      rom_addr_out;
  logic [DW-1:0]      rom_data_in;
  logic [DW-1:0]      data_out;
  logic [N-1:0]       valid_out;

  typedef struct {
    logic [N-1:0]         req;
    logic [N-1:0][AW-1:0] a;
    logic [N-1:0]         exp_grant;
  } vec_t;

  typedef struct {
    int         due;
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  vec_t         vecs[$];
  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] rom_pipe [LAT] = '{default: '0};

  sprite_rom_arbiter #(
    .NUM_REQ     (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .ROM_LATENCY (LAT)
  ) dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .req_in       (req_in),
    .addr_in      (addr_in),
    .grant_out    (grant_out),
    .rom_addr_out (rom_addr_out),
    .rom_data_in  (rom_data_in),
    .data_out     (data_out),
    .valid_out    (valid_out)
  );

  always #5 clk = ~clk;

  // BROM model: data = address low byte, LAT cycles after the address.
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr_out[7:0];
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data_in = rom_pipe[LAT-1];

  function automatic vec_t mk(input logic [N-1:0] r, input int a0, input int a1,
                              input int a2, input int a3, input logic [N-1:0] g);
    vec_t v;
    v.req = r;
    v.a[0] = a0[AW-1:0];
    v.a[1] = a1[AW-1:0];
    v.a[2] = a2[AW-1:0];
    v.a[3] = a3[AW-1:0];
    v.exp_grant = g;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply one vector at a negedge, check after the following rising edge.
  task automatic step(input vec_t v);
    int   gi;
    exp_t e;
    req_in  = v.req;
    addr_in = v.a;
    @(posedge clk);
    #1;
    cyc++;
    check("grant", 32'(grant_out), 32'(v.exp_grant));
    gi = -1;
    for (int i = 0; i < N; i++) if (v.exp_grant[i]) gi = i;
    if (gi >= 0) begin
      last_addr = v.a[gi];
      sb.push_back('{due: cyc + LAT + 1, idx: gi[1:0], data: v.a[gi][7:0]});
    end
    check("rom_addr", 32'(rom_addr_out), 32'(last_addr));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("valid", 32'(valid_out), 32'(4'b0001 << e.idx));
      check("data", 32'(data_out), 32'(e.data));
    end else begin
      check("valid_idle", 32'(valid_out), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    // all requesting, rotating grants
    for (int r = 0; r < 8; r++)
      vecs.push_back(mk(4'b1111, 100, 200, 300, 400, 4'b0001 << (r % 4)));
    // single requester, full throughput
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(4'b0100, 0, 0, k, 0, 4'b0100));
    vecs.push_back(mk(4'b0100, 0, 0, 'h5A3C, 0, 4'b0100));
    // wrap: requesters 3 and 0 alternate
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(4'b1001, 'h11, 0, 0, 'h7FEE, (k % 2 == 0) ? 4'b1000 : 4'b0001));
    // requester 1 raises for one cycle then withdraws
    vecs.push_back(mk(4'b0011, 'h21, 'h22, 0, 0, 4'b0001));
    vecs.push_back(mk(4'b0001, 'h23, 'h22, 0, 0, 4'b0001));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000));

    // reset held with everyone requesting
    req_in  = 4'b1111;
    addr_in = vecs[0].a;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_rom_addr", 32'(rom_addr_out), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    // reset while a read to requester 2 is in flight
    step(mk(4'b0100, 0, 0, 'h77, 0, 4'b0100));
    req_in = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant_out), 32'd0);
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_rom_addr", 32'(rom_addr_out), 32'd0);
    sb.delete();
    last_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(mk(4'b0000, 0, 0, 'h77, 0, 4'b0000));
    step(mk(4'b0100, 0, 0, 'h33, 0, 4'b0100));
    for (int k = 0; k < 5; k++) step(mk(4'b0000, 0, 0, 0, 0, 4'b0000));
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
